// File: rtl/mul_i32_arbiter_if.sv
// Signal bundle between requesters, the shared multiplier and mul_i32_arbiter.
// The master side is the environment and the slave side is the arbiter.
interface mul_i32_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic [NUM_REQ-1:0]        req;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         mul_a;
  logic [DATA_W-1:0]         mul_b;
  logic                      mul_t;
  logic [DATA_W-1:0]         mul_out;
  logic [NUM_REQ-1:0]        res_valid;
  logic [DATA_W-1:0]         res_data;
  logic [CNT_W-1:0]          inflight;

  modport master (
    output req, req_a, req_b, mul_out,
    input  gnt, mul_a, mul_b, mul_t, res_valid, res_data, inflight
  );

  modport slave (
    input  req, req_a, req_b, mul_out,
    output gnt, mul_a, mul_b, mul_t, res_valid, res_data, inflight
  );
endinterface

// File: rtl/mul_i32_arbiter.sv
// Round-robin arbiter sharing one fixed-latency 32-bit multiplier between NUM_REQ requesters.
// A tag pipeline routes each product back to its issuer, in issue order.
module mul_i32_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  mul_i32_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W  = IDX_W + 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [SUM_W-1:0]   cand;
  logic               found;
  logic               issue;
  logic [NUM_REQ-1:0] gnt_oh;

  logic [MUL_LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]       tag_idx [MUL_LATENCY];
  logic                   ret;
  logic [IDX_W-1:0]       ret_idx;

  logic [NUM_REQ-1:0] res_valid_q;
  logic [DATA_W-1:0]  res_data_q;
  logic [CNT_W-1:0]   inflight_q;

  // Round-robin search starting at ptr, wrapping at NUM_REQ; first set request wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = SUM_W'(ptr) + SUM_W'(i);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!found && bus.req[IDX_W'(cand)]) begin
        found = 1'b1;
        gidx  = IDX_W'(cand);
      end
    end
  end

  assign issue = found & ~rst;

  always_comb begin
    gnt_oh = '0;
    if (issue) begin
      gnt_oh[gidx] = 1'b1;
    end
  end

  assign bus.gnt   = gnt_oh;
  assign bus.mul_t = issue;
  assign bus.mul_a = issue ? bus.req_a[DATA_W*gidx +: DATA_W] : '0;
  assign bus.mul_b = issue ? bus.req_b[DATA_W*gidx +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
    end
  end

  // Tag pipeline: one {valid, index} stage per multiplier cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= issue;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    tag_idx[0] <= gidx;
    for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
      tag_idx[i] <= tag_idx[i-1];
    end
  end

  assign ret     = tag_v[MUL_LATENCY-1];
  assign ret_idx = tag_idx[MUL_LATENCY-1];

  // Capture the product in the cycle its tag leaves the pipeline; data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= '0;
      if (ret) begin
        res_valid_q[ret_idx] <= 1'b1;
        res_data_q           <= bus.mul_out;
      end
    end
  end

  // An operation stays counted until its res_valid pulse has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({issue, |res_valid_q})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.inflight  = inflight_q;
endmodule

// File: tb/tb_mul_i32_arbiter.sv
// Directed bench for mul_i32_arbiter with NUM_REQ=4, MUL_LATENCY=2 and a 2-stage multiplier model.
module tb_mul_i32_arbiter;
  localparam logic [127:0] A_SEQ = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] B_TEN = {4{32'd10}};
  localparam logic [127:0] JUNK  = {4{32'hDEAD_BEEF}};

  logic clk;
  logic rst;
  logic [31:0] p1;
  logic [31:0] p2;
  int total;
  int bad;
  int cyc;
  logic [3:0]  exp_rv [0:1023];
  logic [31:0] exp_rd [0:1023];

  mul_i32_arbiter_if #(.NUM_REQ(4)) bus ();

  mul_i32_arbiter #(.NUM_REQ(4), .MUL_LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: product appears two cycles after issue.
  always @(posedge clk) begin
    p1 <= bus.mul_a * bus.mul_b;
    p2 <= p1;
  end
  assign bus.mul_out = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One non-reset cycle: apply inputs, check grant and any result due this cycle.
  task automatic step(input logic [3:0] r, input logic [127:0] a, input logic [127:0] b,
                      input logic [3:0] eg, input logic [31:0] ep);
    @(posedge clk);
    #1;
    cyc++;
    rst       = 1'b0;
    bus.req   = r;
    bus.req_a = a;
    bus.req_b = b;
    #1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("mul_t", 32'(bus.mul_t), 32'(|eg));
    chk("res_valid", 32'(bus.res_valid), 32'(exp_rv[cyc]));
    if (exp_rv[cyc] != 4'b0) chk("res_data", bus.res_data, exp_rd[cyc]);
    if (eg != 4'b0) begin
      exp_rv[cyc+3] = eg;
      exp_rd[cyc+3] = ep;
    end
  endtask

  task automatic rst_cycle(input bit chk_regs);
    @(posedge clk);
    #1;
    cyc++;
    rst       = 1'b1;
    bus.req   = 4'hF;
    bus.req_a = JUNK;
    bus.req_b = JUNK;
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_mul_t", 32'(bus.mul_t), 32'd0);
    chk("rst_mul_a", bus.mul_a, 32'd0);
    chk("rst_mul_b", bus.mul_b, 32'd0);
    if (chk_regs) begin
      chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
      chk("rst_res_data", bus.res_data, 32'd0);
      chk("rst_inflight", 32'(bus.inflight), 32'd0);
    end
    for (int i = cyc + 1; i < 1024; i++) exp_rv[i] = 4'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rst = 1'b1;
    bus.req = 4'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < 1024; i++) begin
      exp_rv[i] = 4'b0;
      exp_rd[i] = 32'd0;
    end

    for (int i = 0; i < 3; i++) rst_cycle(1'b1);

    // Single request from requester 0: 3*7, other lanes carry junk operands.
    step(4'b0001, {32'hFFFF_FFFF, 32'h1234_5678, 32'hCAFE_0001, 32'd3},
                  {32'hFFFF_FFFF, 32'h8765_4321, 32'hCAFE_0002, 32'd7}, 4'b0001, 32'd21);
    chk("s1_mul_a", bus.mul_a, 32'd3);
    chk("s1_mul_b", bus.mul_b, 32'd7);
    chk("s1_inflight0", 32'(bus.inflight), 32'd0);
    for (int c = 1; c < 4; c++) begin
      step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
      chk("s1_inflight", 32'(bus.inflight), 32'd1);
    end
    step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
    chk("s1_inflight_end", 32'(bus.inflight), 32'd0);
    chk("s1_res_hold", bus.res_data, 32'd21);
    chk("s1_idle_mul_a", bus.mul_a, 32'd0);

    // Reset returns the pointer to 0; then all four request continuously.
    rst_cycle(1'b0);
    for (int c = 0; c < 9; c++) begin
      step((c < 5) ? 4'hF : 4'h0, A_SEQ, B_TEN,
           (c < 5) ? 4'(1 << (c % 4)) : 4'h0, 32'(10 * ((c % 4) + 1)));
      if (c == 3) chk("all_inflight_max", 32'(bus.inflight), 32'd3);
    end
    chk("all_inflight_end", 32'(bus.inflight), 32'd0);

    // Fairness: req[3] held, req[0] toggling; pointer starts at 1.
    step(4'b1001, A_SEQ, B_TEN, 4'b1000, 32'd40);
    step(4'b1000, A_SEQ, B_TEN, 4'b1000, 32'd40);
    step(4'b1001, A_SEQ, B_TEN, 4'b0001, 32'd10);
    step(4'b1000, A_SEQ, B_TEN, 4'b1000, 32'd40);
    step(4'b1111, A_SEQ, B_TEN, 4'b0001, 32'd10);
    for (int c = 0; c < 4; c++) step(4'b0000, A_SEQ, B_TEN, 4'b0000, 32'd0);

    // Withdrawal: req[2] dropped before it is reached; pointer starts at 1.
    step(4'b0110, A_SEQ, B_TEN, 4'b0010, 32'd20);
    for (int c = 0; c < 4; c++) step(4'b0000, A_SEQ, B_TEN, 4'b0000, 32'd0);

    // Same requester back to back: pointer at 2.
    step(4'b0100, {32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  {32'd9, 32'd2, 32'd9, 32'd9}, 4'b0100, 32'd10);
    step(4'b0100, {32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  {32'd9, 32'd2, 32'd9, 32'd9}, 4'b0100, 32'd12);
    step(4'b0100, {32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  {32'd9, 32'd2, 32'd9, 32'd9}, 4'b0100, 32'd14);
    step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
    chk("b2b_inflight", 32'(bus.inflight), 32'd3);
    for (int c = 0; c < 3; c++) step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
    chk("b2b_inflight_end", 32'(bus.inflight), 32'd0);

    // Reset mid-operation: pointer at 3, three issues then a one-cycle reset.
    step(4'b1111, A_SEQ, B_TEN, 4'b1000, 32'd40);
    step(4'b1111, A_SEQ, B_TEN, 4'b0001, 32'd10);
    step(4'b1111, A_SEQ, B_TEN, 4'b0010, 32'd20);
    rst_cycle(1'b0);
    for (int c = 0; c < 4; c++) begin
      step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
      chk("rst_mid_inflight", 32'(bus.inflight), 32'd0);
      if (c == 0) chk("rst_mid_res_data", bus.res_data, 32'd0);
    end
    step(4'b0100, A_SEQ, B_TEN, 4'b0100, 32'd30);
    for (int c = 0; c < 4; c++) step(4'b0000, JUNK, JUNK, 4'b0000, 32'd0);
    chk("final_inflight", 32'(bus.inflight), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_i32_arbiter.md
MUL_I32_ARBITER -- requirements
Module: mul_i32_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one multiplier; legal range 2..8.
REQ-002 Parameter MUL_LATENCY, default 2, fixed cycles from multiplier issue to valid product; legal range 1..8.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester request, level; held until granted.
REQ-006 req_a  input  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
REQ-007 req_b  input  32*NUM_REQ  operand B, same packing as req_a.
REQ-008 gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as the accepted req.
REQ-009 mul_a  output  32  operand A driven to the shared multiplier.
REQ-010 mul_b  output  32  operand B driven to the shared multiplier.
REQ-011 mul_t  output  1  issue pulse to the multiplier, equal to |gnt.
REQ-012 mul_out  input  32  multiplier product, valid MUL_LATENCY cycles after issue.
REQ-013 res_valid  output  NUM_REQ  one-hot, registered, product-return pulse.
REQ-014 res_data  output  32  registered product, qualified by res_valid.
REQ-015 inflight  output  4  registered count of issued, not yet returned operations.

Function
REQ-016 Each cycle with rst low and req nonzero, the block SHALL grant exactly one requester; with req zero, gnt SHALL be zero.
REQ-017 Arbitration SHALL be round-robin: search starts at index ptr, wraps from NUM_REQ-1 to 0, first set req bit wins.
REQ-018 On grant to index g, ptr SHALL update to (g+1) mod NUM_REQ at the next edge; with no grant, ptr SHALL hold.
REQ-019 In a grant cycle, mul_a/mul_b SHALL equal req_a/req_b slices of g; otherwise they SHALL be 0.
REQ-020 A tag pipeline of MUL_LATENCY stages, each {valid, index}, SHALL capture {|gnt, g} at each edge and shift one stage per cycle.
REQ-021 For a grant at cycle k, res_valid[g] SHALL be 1 and res_data SHALL equal mul_out sampled at cycle k+MUL_LATENCY, both visible in cycle k+MUL_LATENCY+1.
REQ-022 In cycles with no returning tag, res_valid SHALL be 0 and res_data SHALL hold its last value.
REQ-023 Throughput SHALL be one issue per cycle, with no bubbles under continuous requests.
REQ-024 A requester with req held SHALL be granted within NUM_REQ cycles, regardless of other traffic.
REQ-025 A req deasserted before grant SHALL be withdrawn without side effects.
REQ-026 inflight SHALL increment on issue, decrement on return, and stay unchanged when both occur in the same cycle.
REQ-027 inflight SHALL never exceed MUL_LATENCY+1.
REQ-028 Results SHALL return in issue order; the same requester may have several operations in flight.
REQ-029 req bits at index >= NUM_REQ do not exist; operand values of non-granted requesters SHALL NOT affect any output.

Reset
REQ-030 While rst is high: gnt=0, mul_t=0, mul_a=mul_b=0, res_valid=0, res_data=0, inflight=0, ptr=0, all tag valids cleared.
REQ-031 Operations in flight when rst asserts SHALL be discarded; no res_valid pulse SHALL result from them after rst deasserts.
REQ-032 In the first cycle after rst deasserts, arbitration SHALL start at index 0.

Verification
All scenarios use NUM_REQ=4, MUL_LATENCY=2 and a behavioural 2-cycle multiplier on mul_*.
REQ-033 Single request: req=0001, a=3, b=7 in cycle 0 -> gnt=0001 in cycle 0; res_valid=0001, res_data=21 in cycle 3; inflight 1,1,1,0.
REQ-034 All requesting: req=1111 held, operands a=i+1, b=10:
- grants 0,1,2,3,0 in consecutive cycles;
- res_data 10,20,30,40 with matching one-hot res_valid in cycles 3..6.
REQ-035 Fairness and wrap-around:
- req[3] held continuously; req[0] toggled every cycle;
- req[3] granted within 4 cycles, and after it, ptr=0.
REQ-036 Withdrawal: req=0110 in cycle 0, req[2] dropped in cycle 1 -> grant 1 in cycle 0, no grant in cycle 1, exactly one res_valid pulse (index 1).
REQ-037 Reset mid-operation:
- issue 3 operations back-to-back, assert rst for 1 cycle after the third;
- no res_valid for 4 cycles after reset, inflight=0;
- next request granted normally.
REQ-038 Back-to-back same requester: req=0100 held 3 cycles with b=2, a=5,6,7 -> res_valid=0100 for 3 consecutive cycles with res_data 10,12,14.
